// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the multi-mode counter slice.
//   mode_e         : bound behaviour (MODE_WRAP = wrap around, MODE_SAT = hold)
//   WIDTH_MIN/MAX  : legal range of the counter WIDTH parameter
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    localparam int WIDTH_MIN = 32'd2;
    localparam int WIDTH_MAX = 32'd32;

endpackage : counter_pkg

// File: rtl/sticky_flag.sv
// -----------------------------------------------------------------------------
// sticky_flag
// Single sticky status bit. Set has priority over clear so an event landing on
// the same edge as a clear is never lost.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   set     : set request (wins over clr)
//   clr     : clear request
//   flag    : registered sticky flag
// -----------------------------------------------------------------------------
module sticky_flag (
    input  logic clk,
    input  logic reset_n,
    input  logic set,
    input  logic clr,
    output logic flag
);

    logic flag_r;

    // Sticky flag register: set beats clear, otherwise hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_r <= 1'b0;
        end else if (set) begin
            flag_r <= 1'b1;
        end else if (clr) begin
            flag_r <= 1'b0;
        end else begin
            flag_r <= flag_r;
        end
    end

    assign flag = flag_r;

endmodule : sticky_flag

// File: rtl/multi_mode_counter.sv
// -----------------------------------------------------------------------------
// multi_mode_counter
// Up/down counter over the range [0..limit] with load, wrap-or-saturate bound
// handling, sticky overflow/underflow flags and a one-cycle terminal pulse.
//   Parameters: WIDTH (2..32), SATURATE (0 = wrap, 1 = hold at bound)
//   clk, reset_n   : clock, asynchronous active-low reset
//   enable, up_dn  : step request and direction (1 = up)
//   load, load_val : synchronous load (clamped to limit), beats enable
//   limit          : inclusive upper bound of the count
//   clr_flags      : clears the sticky flags (a coincident event wins)
//   counter_out    : registered count
//   overflow_out   : sticky, up-step taken at the bound
//   underflow_out  : sticky, down-step taken at zero
//   term_pulse     : one-cycle pulse following any overflow/underflow event
// -----------------------------------------------------------------------------
module multi_mode_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] counter_out,
    output logic             overflow_out,
    output logic             underflow_out,
    output logic             term_pulse
);

    localparam mode_e            MODE = mode_e'(SATURATE);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             ovf_evt_s;
    logic             unf_evt_s;
    logic             term_r;

    // Next-count and event decode for load / up-step / down-step / hold.
    always_comb begin
        count_next_s = count_r;
        ovf_evt_s    = 1'b0;
        unf_evt_s    = 1'b0;
        if (load) begin
            count_next_s = (load_val > limit) ? limit : load_val;
        end else if (enable) begin
            if (up_dn) begin
                // A count already above a shrunken limit is also "at the bound".
                if (count_r < limit) begin
                    count_next_s = count_r + ONE;
                end else begin
                    ovf_evt_s    = 1'b1;
                    count_next_s = (MODE == MODE_SAT) ? limit : '0;
                end
            end else begin
                if (count_r == '0) begin
                    unf_evt_s    = 1'b1;
                    count_next_s = (MODE == MODE_SAT) ? '0 : limit;
                end else if (count_r > limit) begin
                    // Step back into range rather than decrementing past it.
                    count_next_s = limit;
                end else begin
                    count_next_s = count_r - ONE;
                end
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register and terminal pulse register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
            term_r  <= 1'b0;
        end else begin
            count_r <= count_next_s;
            term_r  <= ovf_evt_s | unf_evt_s;
        end
    end

    sticky_flag u_ovf_flag (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (ovf_evt_s),
        .clr     (clr_flags),
        .flag    (overflow_out)
    );

    sticky_flag u_unf_flag (
        .clk     (clk),
        .reset_n (reset_n),
        .set     (unf_evt_s),
        .clr     (clr_flags),
        .flag    (underflow_out)
    );

    assign counter_out = count_r;
    assign term_pulse  = term_r;

endmodule : multi_mode_counter

// File: tb/tb_multi_mode_counter.sv
module tb_multi_mode_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       up_dn = 1'b0;
    logic       load = 1'b0;
    logic       clr_flags = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] limit = 4'd0;

    // index 0: wrap instance, index 1: saturate instance
    logic [3:0] cnt_o  [2];
    logic       ovf_o  [2];
    logic       unf_o  [2];
    logic       term_o [2];

    int n_cmp = 0;
    int n_mis = 0;

    // reference model state
    int m_cnt  [2];
    bit m_ovf  [2];
    bit m_unf  [2];
    bit m_term [2];

    multi_mode_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
        .load(load), .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
        .counter_out(cnt_o[0]), .overflow_out(ovf_o[0]),
        .underflow_out(unf_o[0]), .term_pulse(term_o[0])
    );

    multi_mode_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .up_dn(up_dn),
        .load(load), .load_val(load_val), .limit(limit), .clr_flags(clr_flags),
        .counter_out(cnt_o[1]), .overflow_out(ovf_o[1]),
        .underflow_out(unf_o[1]), .term_pulse(term_o[1])
    );

    initial forever #5 clk = ~clk;

    task automatic model_zero();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_term[i] = 0;
        end
    endtask

    // behavioural model of one clock edge, from the counting rules
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit sat = (i == 1);
            int c   = m_cnt[i];
            int lim = int'(limit);
            bit ev_o = 0;
            bit ev_u = 0;
            if (load) begin
                c = (int'(load_val) > lim) ? lim : int'(load_val);
            end else if (enable && up_dn) begin
                if (c < lim) c = c + 1;
                else begin ev_o = 1; c = sat ? lim : 0; end
            end else if (enable) begin
                if (c == 0) begin ev_u = 1; c = sat ? 0 : lim; end
                else c = (c - 1 < lim) ? c - 1 : lim;
            end
            m_cnt[i]  = c;
            m_term[i] = ev_o | ev_u;
            if (ev_o) m_ovf[i] = 1; else if (clr_flags) m_ovf[i] = 0;
            if (ev_u) m_unf[i] = 1; else if (clr_flags) m_unf[i] = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b0; up_dn = 1'b0; load = 1'b0; clr_flags = 1'b0; load_val = 4'd0;
    endtask

    task automatic do_reset();
        #2;
        reset_n = 1'b0;
        idle_inputs();
        model_zero();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (cnt_o[i] !== 4'd0) begin n_mis++; $display("FAIL reset_cnt[%0d]: got %0d want 0", i, cnt_o[i]); end
            n_cmp++; if (ovf_o[i] !== 1'b0) begin n_mis++; $display("FAIL reset_ovf[%0d]: got %b want 0", i, ovf_o[i]); end
            n_cmp++; if (unf_o[i] !== 1'b0) begin n_mis++; $display("FAIL reset_unf[%0d]: got %b want 0", i, unf_o[i]); end
            n_cmp++; if (term_o[i] !== 1'b0) begin n_mis++; $display("FAIL reset_term[%0d]: got %b want 0", i, term_o[i]); end
        end
    endtask

    task automatic test_wrap_up();
        do_reset();
        limit = 4'd9; enable = 1'b1; up_dn = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] exp_c;
            exp_c = 4'(k % 10);
            tick();
            n_cmp++; if (cnt_o[0] !== exp_c) begin n_mis++; $display("FAIL wrap_cnt step%0d: got %0d want %0d", k, cnt_o[0], exp_c); end
            n_cmp++; if (term_o[0] !== (k == 10)) begin n_mis++; $display("FAIL wrap_term step%0d: got %b want %b", k, term_o[0], (k == 10)); end
        end
        n_cmp++; if (ovf_o[0] !== 1'b1) begin n_mis++; $display("FAIL wrap_ovf: got %b want 1", ovf_o[0]); end
        n_cmp++; if (cnt_o[1] !== 4'd9) begin n_mis++; $display("FAIL wrap_sat_hold: got %0d want 9", cnt_o[1]); end
        enable = 1'b0;
        tick();
        n_cmp++; if (term_o[0] !== 1'b0) begin n_mis++; $display("FAIL wrap_term_drop: got %b want 0", term_o[0]); end
        n_cmp++; if (ovf_o[0] !== 1'b1) begin n_mis++; $display("FAIL wrap_ovf_sticky: got %b want 1", ovf_o[0]); end
    endtask

    task automatic test_sat_down();
        logic [3:0] exp_c [4];
        logic       exp_t [4];
        exp_c = '{4'd1, 4'd0, 4'd0, 4'd0};
        exp_t = '{1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        limit = 4'd9; load = 1'b1; load_val = 4'd2;
        tick();
        load = 1'b0; enable = 1'b1; up_dn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++; if (cnt_o[1] !== exp_c[k]) begin n_mis++; $display("FAIL satdn_cnt step%0d: got %0d want %0d", k, cnt_o[1], exp_c[k]); end
            n_cmp++; if (term_o[1] !== exp_t[k]) begin n_mis++; $display("FAIL satdn_term step%0d: got %b want %b", k, term_o[1], exp_t[k]); end
        end
        n_cmp++; if (unf_o[1] !== 1'b1) begin n_mis++; $display("FAIL satdn_unf: got %b want 1", unf_o[1]); end
        // wrap instance: 2,1,0 then underflow to 9, then 8
        n_cmp++; if (cnt_o[0] !== 4'd8) begin n_mis++; $display("FAIL satdn_wrap_cnt: got %0d want 8", cnt_o[0]); end
        idle_inputs();
    endtask

    task automatic test_load_clamp();
        do_reset();
        limit = 4'd5; load = 1'b1; load_val = 4'd12; enable = 1'b1; up_dn = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (cnt_o[i] !== 4'd5) begin n_mis++; $display("FAIL clamp_cnt[%0d]: got %0d want 5", i, cnt_o[i]); end
            n_cmp++; if ({ovf_o[i], unf_o[i], term_o[i]} !== 3'b000) begin n_mis++; $display("FAIL clamp_flags[%0d]: got %b want 000", i, {ovf_o[i], unf_o[i], term_o[i]}); end
        end
        idle_inputs();
    endtask

    task automatic test_clr_vs_set();
        do_reset();
        limit = 4'd9; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; enable = 1'b1; up_dn = 1'b1; clr_flags = 1'b1;
        tick();
        n_cmp++; if (ovf_o[0] !== 1'b1) begin n_mis++; $display("FAIL clrset_ovf: got %b want 1", ovf_o[0]); end
        n_cmp++; if (cnt_o[0] !== 4'd0) begin n_mis++; $display("FAIL clrset_cnt: got %0d want 0", cnt_o[0]); end
        enable = 1'b0;
        tick();
        n_cmp++; if (ovf_o[0] !== 1'b0) begin n_mis++; $display("FAIL clr_alone_ovf: got %b want 0", ovf_o[0]); end
        n_cmp++; if (ovf_o[1] !== 1'b0) begin n_mis++; $display("FAIL clr_alone_ovf_sat: got %b want 0", ovf_o[1]); end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        limit = 4'd9; load = 1'b1; load_val = 4'd9;
        tick();
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        tick();
        enable = 1'b0; load = 1'b1; load_val = 4'd7;
        tick();
        n_cmp++; if (cnt_o[0] !== 4'd7 || ovf_o[0] !== 1'b1) begin n_mis++; $display("FAIL arst_pre: got cnt %0d ovf %b want 7 1", cnt_o[0], ovf_o[0]); end
        // load still pending on the inputs when reset hits mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if ({cnt_o[i], ovf_o[i], unf_o[i], term_o[i]} !== 7'd0) begin n_mis++; $display("FAIL arst_now[%0d]: got %b want 0", i, {cnt_o[i], ovf_o[i], unf_o[i], term_o[i]}); end
        end
        @(posedge clk); #1;
        n_cmp++; if (cnt_o[0] !== 4'd0) begin n_mis++; $display("FAIL arst_hold: got %0d want 0", cnt_o[0]); end
        do_reset();
    endtask

    task automatic test_limit_shrink();
        do_reset();
        limit = 4'd15; load = 1'b1; load_val = 4'd8;
        tick();
        load = 1'b0; limit = 4'd3; enable = 1'b1; up_dn = 1'b1;
        tick();
        n_cmp++; if (cnt_o[0] !== 4'd0 || term_o[0] !== 1'b1 || ovf_o[0] !== 1'b1) begin n_mis++; $display("FAIL shrink_up: got cnt %0d term %b ovf %b want 0 1 1", cnt_o[0], term_o[0], ovf_o[0]); end
        n_cmp++; if (cnt_o[1] !== 4'd3 || term_o[1] !== 1'b1) begin n_mis++; $display("FAIL shrink_up_sat: got cnt %0d term %b want 3 1", cnt_o[1], term_o[1]); end
        do_reset();
        limit = 4'd15; load = 1'b1; load_val = 4'd8;
        tick();
        load = 1'b0; limit = 4'd3; enable = 1'b1; up_dn = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (cnt_o[i] !== 4'd3 || term_o[i] !== 1'b0 || unf_o[i] !== 1'b0) begin n_mis++; $display("FAIL shrink_dn[%0d]: got cnt %0d term %b unf %b want 3 0 0", i, cnt_o[i], term_o[i], unf_o[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_limit_zero();
        do_reset();
        limit = 4'd0; enable = 1'b1; up_dn = 1'b1;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (cnt_o[i] !== 4'd0 || term_o[i] !== 1'b1 || ovf_o[i] !== 1'b1) begin n_mis++; $display("FAIL lim0_up[%0d]: got cnt %0d term %b ovf %b want 0 1 1", i, cnt_o[i], term_o[i], ovf_o[i]); end
        end
        up_dn = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (cnt_o[i] !== 4'd0 || term_o[i] !== 1'b1 || unf_o[i] !== 1'b1) begin n_mis++; $display("FAIL lim0_dn[%0d]: got cnt %0d term %b unf %b want 0 1 1", i, cnt_o[i], term_o[i], unf_o[i]); end
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        limit = 4'($urandom_range(0, 15));
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) limit = 4'($urandom_range(0, 15));
            load      = ($urandom_range(0, 9) == 0);
            load_val  = 4'($urandom_range(0, 15));
            enable    = ($urandom_range(0, 3) != 0);
            up_dn     = ($urandom_range(0, 1) == 1);
            clr_flags = ($urandom_range(0, 7) == 0);
            if (k % 150 == 149) begin
                do_reset();
            end else begin
                tick();
            end
            for (int i = 0; i < 2; i++) begin
                n_cmp++; if (cnt_o[i] !== 4'(m_cnt[i])) begin n_mis++; $display("FAIL rnd_cnt[%0d] cyc%0d: got %0d want %0d", i, k, cnt_o[i], m_cnt[i]); end
                n_cmp++; if (ovf_o[i] !== m_ovf[i]) begin n_mis++; $display("FAIL rnd_ovf[%0d] cyc%0d: got %b want %b", i, k, ovf_o[i], m_ovf[i]); end
                n_cmp++; if (unf_o[i] !== m_unf[i]) begin n_mis++; $display("FAIL rnd_unf[%0d] cyc%0d: got %b want %b", i, k, unf_o[i], m_unf[i]); end
                n_cmp++; if (term_o[i] !== m_term[i]) begin n_mis++; $display("FAIL rnd_term[%0d] cyc%0d: got %b want %b", i, k, term_o[i], m_term[i]); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_clr_vs_set();
        test_async_reset();
        test_limit_shrink();
        test_limit_zero();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_multi_mode_counter

// File: doc/multi_mode_counter.md
MULTI_MODE_COUNTER -- requirements
Module: multi_mode_counter

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits (legal range 2..32).
REQ-002 SHALL provide parameter SATURATE, default 0: 0 = wrap at the bound, 1 = hold at the bound.
REQ-003 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide port enable, input, 1, count step request this cycle.
REQ-006 SHALL provide port up_dn, input, 1, direction: 1 = increment, 0 = decrement.
REQ-007 SHALL provide port load, input, 1, synchronous load request.
REQ-008 SHALL provide port load_val, input, WIDTH, value to load.
REQ-009 SHALL provide port limit, input, WIDTH, inclusive upper bound of the count range [0..limit].
REQ-010 SHALL provide port clr_flags, input, 1, clears the sticky flags.
REQ-011 SHALL provide port counter_out, output, WIDTH, registered count.
REQ-012 SHALL provide port overflow_out, output, 1, sticky flag: an up-step occurred at the bound.
REQ-013 SHALL provide port underflow_out, output, 1, sticky flag: a down-step occurred at 0.
REQ-014 SHALL provide port term_pulse, output, 1, one-cycle registered pulse on each overflow or underflow event.

Function
REQ-015 All outputs SHALL be registered; an input sampled at edge N is reflected at counter_out after edge N (one-cycle latency).
REQ-016 Priority SHALL be: load > enable; enable=0 with load=0 holds the count.
REQ-017 On load, counter_out SHALL become min(load_val, limit); no flag or pulse is generated.
REQ-018 Up-step with counter_out < limit SHALL increment by 1.
REQ-019 Up-step with counter_out >= limit SHALL be an overflow event: next count is 0 (SATURATE=0) or limit (SATURATE=1).
REQ-020 Down-step with counter_out > 0 SHALL decrement by 1; if counter_out > limit, the next count is limit instead.
REQ-021 Down-step with counter_out == 0 SHALL be an underflow event: next count is limit (SATURATE=0) or 0 (SATURATE=1).
REQ-022 Each event SHALL set its sticky flag and assert term_pulse for exactly the following cycle; the event is raised in SATURATE mode too.
REQ-023 Sticky flags SHALL hold until clr_flags; when clr_flags and a new event coincide, set wins.
REQ-024 limit == 0 SHALL be legal: every up-step is an overflow event and every down-step is an underflow event; the count stays 0.
REQ-025 A change of limit SHALL take effect on the next step; counter_out is not modified without a step or a load.
REQ-026 Arithmetic SHALL be WIDTH bits, unsigned, with no carry out beyond WIDTH.

Reset
REQ-027 reset_n low SHALL asynchronously force counter_out=0, overflow_out=0, underflow_out=0 and term_pulse=0, regardless of clk.
REQ-028 Deassertion of reset_n SHALL be synchronised by the integrator; the first step may occur on the first rising edge after release.
REQ-029 Reset asserted mid-count SHALL discard any pending load or event pulse.

Structure
REQ-030 Shared package counter_pkg SHALL hold the mode encoding (MODE_WRAP=0, MODE_SAT=1) and the WIDTH legal-range constants.
REQ-031 One sub-module, sticky_flag (set/clear, set wins, async active-low reset), SHALL be instantiated twice for the overflow and underflow flags.
REQ-032 The next-count logic SHALL be a single combinational block feeding one register bank.

Verification
REQ-033 Wrap, up: WIDTH=4, SATURATE=0, limit=9, enable=1, up_dn=1 from reset -> count 0..9,0; overflow_out=1 and term_pulse high one cycle after the 9->0 edge.
REQ-034 Saturate, down: SATURATE=1, limit=9, load 2, then 4 down-steps -> count 1,0,0,0; underflow_out set and term_pulse high for 1 cycle after each of the last two steps.
REQ-035 Load clamp and priority: limit=5, load=1, load_val=12, enable=1 -> count 5, no flag, no pulse.
REQ-036 Clear versus set: count=9, limit=9, up-step with clr_flags=1 on the same edge -> overflow_out stays 1; clr_flags alone on the next edge -> 0.
REQ-037 Async reset: assert reset_n=0 between clock edges with count=7 and flags set -> all outputs 0 immediately, before the next edge.
REQ-038 Limit shrink: count=8, limit changed to 3, then one up-step -> overflow event and count 0; with a down-step instead -> count 3 and no event.
